// File: rtl/ram_bus_arbiter_if.sv
// Bus bundle for ram_bus_arbiter: both Wishbone master ports, the SRAM slave port
// and the grant vector. The arbiter uses the slave modport, the surrounding system uses master.
interface ram_bus_arbiter_if;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic [3:0]  m0_sel_i;
    logic        m0_ack_o, m0_err_o;

    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o, m1_err_o;

    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_ack_i, s_err_i;

    logic [1:0]  gnt_o;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i,
        output m0_dat_o, m0_ack_o, m0_err_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i,
        output m1_dat_o, m1_ack_o, m1_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
        input  s_dat_i, s_ack_i, s_err_i,
        output gnt_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i,
        input  m0_dat_o, m0_ack_o, m0_err_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i,
        input  m1_dat_o, m1_ack_o, m1_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
        output s_dat_i, s_ack_i, s_err_i,
        input  gnt_o
    );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Two-master Wishbone arbiter in front of the 32-bit SRAM slave, with a watchdog
// that aborts transfers the slave never answers.
// Optional feature: define RAM_ARB_ROUND_ROBIN_EN for round-robin priority
// (default build is fixed priority, m0 wins).
module ram_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk_bus,
    input  logic             rst_bus,
    ram_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               s_cyc_q, s_stb_q, s_we_q;
    logic [31:0]        s_adr_q, s_dat_q;
    logic [3:0]         s_sel_q;
    logic [1:0]         gnt_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic               last_q;     // 1: m1 was granted last
`endif

    logic req0, req1, pick0, pick1, busy;
    logic timeout, resp_ack, resp_err, done;

    // Arbitration, watchdog and completion decode; next state and next count
    always_comb begin
        req0 = bus.m0_cyc_i & bus.m0_stb_i;
        req1 = bus.m1_cyc_i & bus.m1_stb_i;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        pick0 = req0 & (~req1 | last_q);
`else
        pick0 = req0;
`endif
        pick1 = req1 & ~pick0;
        busy  = (state_q != IDLE);

        // Slave answers take precedence over the watchdog; err beats ack
        timeout  = busy & (cnt_q == CNT_W'(TIMEOUT_CYCLES)) & ~bus.s_ack_i & ~bus.s_err_i;
        resp_err = busy & (bus.s_err_i | timeout);
        resp_ack = busy & bus.s_ack_i & ~bus.s_err_i;
        done     = resp_err | resp_ack;

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick0)      state_d = BUSY0;
                else if (pick1) state_d = BUSY1;
            end
            BUSY0, BUSY1: begin
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Counter includes the grant cycle so it equals the cycle number after the request
        if (busy)               cnt_d = cnt_q + CNT_W'(1);
        else if (pick0 | pick1) cnt_d = CNT_W'(1);
        else                    cnt_d = '0;
    end

    // State, captured transfer and grant registers
    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_cyc_q <= 1'b0;
            s_stb_q <= 1'b0;
            s_we_q  <= 1'b0;
            s_adr_q <= '0;
            s_sel_q <= '0;
            s_dat_q <= '0;
            gnt_q   <= 2'b00;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE) begin
                if (pick0 | pick1) begin
                    s_cyc_q <= 1'b1;
                    s_stb_q <= 1'b1;
                    gnt_q   <= {pick1, pick0};
                    s_we_q  <= pick1 ? bus.m1_we_i  : bus.m0_we_i;
                    s_adr_q <= pick1 ? bus.m1_adr_i : bus.m0_adr_i;
                    s_sel_q <= pick1 ? bus.m1_sel_i : bus.m0_sel_i;
                    s_dat_q <= pick1 ? bus.m1_dat_i : bus.m0_dat_i;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    last_q  <= pick1;
`endif
                end
            end else begin
                // Slave latches the strobe on the first edge, so it is a single-cycle pulse
                s_stb_q <= 1'b0;
                if (done) begin
                    s_cyc_q <= 1'b0;
                    gnt_q   <= 2'b00;
                end
            end
        end
    end

    assign bus.s_cyc_o = s_cyc_q;
    assign bus.s_stb_o = s_stb_q;
    assign bus.s_we_o  = s_we_q;
    assign bus.s_adr_o = s_adr_q;
    assign bus.s_sel_o = s_sel_q;
    assign bus.s_dat_o = s_dat_q;
    assign bus.gnt_o   = gnt_q;

    // Responses go only to the owner, and only while it still holds its cycle
    assign bus.m0_ack_o = resp_ack & (state_q == BUSY0) & bus.m0_cyc_i & ~rst_bus;
    assign bus.m0_err_o = resp_err & (state_q == BUSY0) & bus.m0_cyc_i & ~rst_bus;
    assign bus.m1_ack_o = resp_ack & (state_q == BUSY1) & bus.m1_cyc_i & ~rst_bus;
    assign bus.m1_err_o = resp_err & (state_q == BUSY1) & bus.m1_cyc_i & ~rst_bus;
    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter with a small SRAM slave model (ack two edges after strobe).
module tb_ram_bus_arbiter;

    logic clk_bus = 1'b0;
    logic rst_bus = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    ram_bus_arbiter_if bus ();

    ram_bus_arbiter #(.TIMEOUT_CYCLES(15), .CNT_W(8)) dut (
        .clk_bus (clk_bus),
        .rst_bus (rst_bus),
        .bus     (bus)
    );

    always #5 clk_bus = ~clk_bus;

    // SRAM slave model: latches strobe on an edge, answers on the following edge
    logic        sl_stage = 1'b0, sl_ack = 1'b0, sl_err = 1'b0;
    logic        sl_ack_en = 1'b1, sl_err_en = 1'b0;
    logic [31:0] sl_rdata = 32'h0;
    always @(posedge clk_bus) begin
        sl_stage <= bus.s_cyc_o & bus.s_stb_o;
        sl_ack   <= sl_stage & sl_ack_en;
        sl_err   <= sl_stage & sl_err_en;
    end
    assign bus.s_ack_i = sl_ack;
    assign bus.s_err_i = sl_err;
    assign bus.s_dat_i = sl_ack ? sl_rdata : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start of next cycle (inputs driven here) and mid-cycle sample point
    task automatic nc();
        @(posedge clk_bus);
        #1;
    endtask
    task automatic sm();
        @(negedge clk_bus);
    endtask

    task automatic set_req(input int m, input logic we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat);
        if (m == 0) begin
            bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_we_i = we;
            bus.m0_adr_i = adr;  bus.m0_sel_i = sel;  bus.m0_dat_i = dat;
        end else begin
            bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_we_i = we;
            bus.m1_adr_i = adr;  bus.m1_sel_i = sel;  bus.m1_dat_i = dat;
        end
    endtask

    task automatic clr_req();
        bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
        bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_gnt;
        clr_req();
        bus.m0_we_i = 1'b0; bus.m0_adr_i = '0; bus.m0_sel_i = '0; bus.m0_dat_i = '0;
        bus.m1_we_i = 1'b0; bus.m1_adr_i = '0; bus.m1_sel_i = '0; bus.m1_dat_i = '0;

        // Reset state
        repeat (3) nc();
        rst_bus = 1'b0;
        sm();
        chk("rst_gnt",   32'(bus.gnt_o),   32'h0);
        chk("rst_s_cyc", 32'(bus.s_cyc_o), 32'h0);
        chk("rst_s_stb", 32'(bus.s_stb_o), 32'h0);
        chk("rst_acks",  32'({bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o}), 32'h0);

        // m0 read of 0x10, slave returns DEADBEEF
        sl_rdata = 32'hDEAD_BEEF;
        nc(); set_req(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0);       // cycle 0
        sm(); chk("rd_c0_gnt", 32'(bus.gnt_o), 32'h0);
        nc(); sm();                                                // cycle 1
        chk("rd_c1_gnt",   32'(bus.gnt_o),   32'h1);
        chk("rd_c1_stb",   32'(bus.s_stb_o), 32'h1);
        chk("rd_c1_cyc",   32'(bus.s_cyc_o), 32'h1);
        chk("rd_c1_adr",   bus.s_adr_o,      32'h0000_0010);
        chk("rd_c1_we",    32'(bus.s_we_o),  32'h0);
        nc(); sm();                                                // cycle 2
        chk("rd_c2_stb",   32'(bus.s_stb_o),  32'h0);
        chk("rd_c2_ack",   32'(bus.m0_ack_o), 32'h0);
        nc(); sm();                                                // cycle 3
        chk("rd_c3_ack",   32'(bus.m0_ack_o), 32'h1);
        chk("rd_c3_dat",   bus.m0_dat_o,      32'hDEAD_BEEF);
        chk("rd_c3_m1ack", 32'(bus.m1_ack_o), 32'h0);
        nc(); clr_req(); sm();                                     // cycle 4
        chk("rd_c4_cyc",   32'(bus.s_cyc_o), 32'h0);
        chk("rd_c4_gnt",   32'(bus.gnt_o),   32'h0);
        nc();

        // m1 write 12345678, all byte lanes
        nc(); set_req(1, 1'b1, 32'h0000_0100, 4'hF, 32'h1234_5678); // cycle 0
        nc(); sm();                                                  // cycle 1
        chk("wr_c1_gnt",  32'(bus.gnt_o),  32'h2);
        chk("wr_c1_dat",  bus.s_dat_o,     32'h1234_5678);
        chk("wr_c1_we",   32'(bus.s_we_o), 32'h1);
        chk("wr_c1_sel",  32'(bus.s_sel_o), 32'hF);
        nc(); sm();                                                  // cycle 2
        chk("wr_c2_ack",  32'(bus.m1_ack_o), 32'h0);
        nc(); sm();                                                  // cycle 3
        chk("wr_c3_ack",   32'(bus.m1_ack_o), 32'h1);
        chk("wr_c3_m0ack", 32'(bus.m0_ack_o), 32'h0);
        nc(); clr_req(); nc();

        // Both masters hold requests across four transfers
        nc();
        set_req(0, 1'b0, 32'h0000_0020, 4'hF, 32'h0);
        set_req(1, 1'b0, 32'h0000_0040, 4'hF, 32'h0);              // cycle 0
        for (int t = 0; t < 4; t++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            exp_gnt = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_gnt = 2'b01;
`endif
            nc(); sm();                                            // cycle 4t+1
            chk($sformatf("arb_gnt%0d", t), 32'(bus.gnt_o), 32'(exp_gnt));
            nc(); nc(); sm();                                      // cycle 4t+3
            chk($sformatf("arb_ack%0d", t), 32'({bus.m1_ack_o, bus.m0_ack_o}), 32'(exp_gnt));
            nc();                                                  // cycle 4t+4
            if (t == 3) clr_req();
        end
        nc(); sm();
        chk("arb_idle_gnt", 32'(bus.gnt_o), 32'h0);

        // Watchdog: slave never answers
        sl_ack_en = 1'b0;
        nc(); set_req(0, 1'b0, 32'h0000_0080, 4'hF, 32'h0);       // cycle 0
        repeat (14) nc();
        sm();                                                      // cycle 14
        chk("wd_c14_err", 32'(bus.m0_err_o), 32'h0);
        nc(); sm();                                                // cycle 15
        chk("wd_c15_err",   32'(bus.m0_err_o), 32'h1);
        chk("wd_c15_ack",   32'(bus.m0_ack_o), 32'h0);
        chk("wd_c15_m1err", 32'(bus.m1_err_o), 32'h0);
        chk("wd_c15_gnt",   32'(bus.gnt_o),    32'h1);
        nc(); clr_req(); sm();                                     // cycle 16
        chk("wd_c16_err", 32'(bus.m0_err_o), 32'h0);
        chk("wd_c16_cyc", 32'(bus.s_cyc_o),  32'h0);
        chk("wd_c16_gnt", 32'(bus.gnt_o),    32'h0);
        nc();

        // Slave asserts ack and err together
        sl_ack_en = 1'b1; sl_err_en = 1'b1;
        nc(); set_req(1, 1'b0, 32'h0000_0200, 4'hF, 32'h0);       // cycle 0
        nc(); nc(); nc(); sm();                                    // cycle 3
        chk("ae_m1err", 32'(bus.m1_err_o), 32'h1);
        chk("ae_m1ack", 32'(bus.m1_ack_o), 32'h0);
        chk("ae_m0err", 32'(bus.m0_err_o), 32'h0);
        nc(); clr_req(); nc();
        sl_err_en = 1'b0;

        // Reset pulsed in cycle 2 of a transfer, then a normal transfer
        sl_rdata = 32'hCAFE_F00D;
        nc(); set_req(0, 1'b0, 32'h0000_0300, 4'hF, 32'h0);       // cycle 0
        nc(); sm();                                                // cycle 1
        chk("rs_c1_gnt", 32'(bus.gnt_o), 32'h1);
        nc(); rst_bus = 1'b1;                                      // cycle 2
        nc(); rst_bus = 1'b0; sm();                                // cycle 3
        chk("rs_c3_cyc", 32'(bus.s_cyc_o),  32'h0);
        chk("rs_c3_stb", 32'(bus.s_stb_o),  32'h0);
        chk("rs_c3_gnt", 32'(bus.gnt_o),    32'h0);
        chk("rs_c3_ack", 32'(bus.m0_ack_o), 32'h0);
        nc(); sm();                                                // regrant cycle
        chk("rs_re_gnt", 32'(bus.gnt_o), 32'h1);
        nc(); nc(); sm();
        chk("rs_re_ack", 32'(bus.m0_ack_o), 32'h1);
        chk("rs_re_dat", bus.m0_dat_o,      32'hCAFE_F00D);
        nc(); clr_req(); nc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_bus_arbiter.md
# ram_bus_arbiter

Two-master Wishbone arbiter that shares the single 32-bit SRAM slave port between the data-side master (m0) and the instruction-fetch master (m1). It sits between the CPU bus masters and the SRAM slave controller. It grants one master at a time, registers and forwards that master's transfer to the slave, and routes ack/err/data back. A watchdog terminates any transfer the slave never acknowledges.

## Interface
- TIMEOUT_CYCLES, 15: busy cycles without slave ack before the watchdog aborts (1..255).
- CNT_W, 8: watchdog counter width.
- clk_bus  in  1  bus clock, all logic on rising edge.
- rst_bus  in  1  reset, synchronous and active-high.
- mN_cyc_i  in  1  master N bus cycle (N = 0, 1; one port per master for this and every mN_ line).
- mN_stb_i  in  1  master N strobe; a request is mN_cyc_i & mN_stb_i.
- mN_we_i  in  1  master N write enable.
- mN_adr_i  in  32  master N byte address.
- mN_sel_i  in  4  master N byte selects.
- mN_dat_i  in  32  master N write data.
- mN_dat_o  out  32  read data, driven from s_dat_i to both masters.
- mN_ack_o  out  1  transfer complete for master N.
- mN_err_o  out  1  transfer failed for master N (slave err or watchdog).
- s_cyc_o  out  1  slave bus cycle.
- s_stb_o  out  1  slave strobe, one-cycle pulse per transfer.
- s_we_o  out  1  slave write enable.
- s_adr_o  out  32  slave address.
- s_sel_o  out  4  slave byte selects.
- s_dat_o  out  32  slave write data.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave acknowledge.
- s_err_i  in  1  slave error.
- gnt_o  out  2  one-hot current owner, 00 when idle.

## Operation
- States: IDLE, BUSY0, BUSY1.
- IDLE: sample requests. Grant by the priority rule below, then go to BUSYn. Capture mN_we/adr/sel/dat into s_* registers. Set s_cyc_o = s_stb_o = 1 and clear the watchdog.
- BUSYn: s_stb_o drops to 0 after its first cycle, because the slave latches on the first edge. s_cyc_o stays 1. The watchdog increments each cycle.
- Completion: s_ack_i or s_err_i high in BUSYn. mN_ack_o / mN_err_o of the owner follow combinationally in that cycle, gated by state. Next edge: s_cyc_o = 0, state IDLE.
- Watchdog: counter == TIMEOUT_CYCLES with no ack/err asserts the owner's mN_err_o for that cycle. Next edge: s_cyc_o = 0, state IDLE.
- The non-owner's ack/err are always 0. Simultaneous ack and err: err wins and ack is suppressed.
- The owner dropping mN_cyc_i mid-transfer does not abort. The slave transfer runs to ack, err or timeout, and the response is not delivered.
- Priority: m0 wins when both masters request, unless round-robin is compiled in (see Configuration).
- At least one IDLE cycle separates any two grants.

## Timing
- Reset: state IDLE. All outputs 0, gnt_o = 00, watchdog 0, round-robin pointer "last = m1".
- Reset asserted mid-transfer: s_cyc_o and s_stb_o are 0 after the edge. No ack/err is delivered.
- Request visible in cycle 0 → grant registered at edge 1. With the SRAM slave, ack arrives after edge 3, so mN_ack_o is high in cycle 3. Read latency is 3 cycles; write latency is the same.
- mN_dat_o is valid only while mN_ack_o is high.
- Watchdog: err is asserted in cycle TIMEOUT_CYCLES after the grant cycle.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN defined: a one-bit pointer records the last granted master. On simultaneous requests, the other master wins. A lone requester always wins, and the pointer updates on every grant.
- Undefined: fixed priority, m0 always wins, no pointer register.

## Test plan
- m0 read of 0x0000_0010, slave returns 0xDEAD_BEEF → m0_ack_o high in cycle 3, m0_dat_o = 0xDEAD_BEEF, s_stb_o high exactly 1 cycle, gnt_o = 01.
- m1 write 0x1234_5678, sel 1111 → s_dat_o = 0x1234_5678 and s_we_o = 1 from cycle 1, m1_ack_o high in cycle 3, m0_ack_o stays 0.
- Both masters hold requests for 4 transfers → fixed priority: four m0 grants. With RAM_ARB_ROUND_ROBIN_EN: grants alternate m0, m1, m0, m1.
- Slave never acks, TIMEOUT_CYCLES = 15 → owner's err high in cycle 15 for 1 cycle, then s_cyc_o = 0 and gnt_o = 00.
- Slave asserts ack and err together → only the owner's err_o is high.
- rst_bus pulsed in cycle 2 of a transfer → s_cyc_o = 0 next cycle, no ack delivered, and the next request is granted normally.
